// File: rtl/wddl_round_seq.sv
`default_nettype none
// ============================================================================
// Module      : wddl_round_seq
// Description : Phase and round sequencer for the WDDL AES datapath.
//               Alternates the dual-rail gate network between precharge
//               (all rails low) and evaluate, counts AES rounds 0..NUM_ROUNDS
//               and strobes the state/key register enable in the last cycle
//               of every evaluate window.
// Ports       : clk           - clock, rising edge
//               rst_n         - asynchronous active-low reset
//               start_i       - start request (sampled only in IDLE)
//               abort_i       - abandon current operation, return to IDLE
//               prech_o       - datapath in precharge
//               eval_o        - datapath evaluating (always ~prech_o)
//               round_o       - current round index
//               first_round_o - round 0 while busy
//               last_round_o  - round NUM_ROUNDS while busy
//               reg_en_o      - state/key register capture strobe
//               busy_o        - operation in progress (PRECH or EVAL)
//               done_o        - one-cycle pulse, result registers valid
// Revision    : 1.0 - initial release
// ============================================================================
module wddl_round_seq #(
    parameter int NUM_ROUNDS  = 10,
    parameter int PRE_CYCLES  = 1,
    parameter int EVAL_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             prech_o,
    output logic             eval_o,
    output logic [CNT_W-1:0] round_o,
    output logic             first_round_o,
    output logic             last_round_o,
    output logic             reg_en_o,
    output logic             busy_o,
    output logic             done_o
);

    // Phase counter only ever needs to reach the longer of the two phases.
    localparam int c_PH_MAX = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
    localparam int c_PH_W   = (c_PH_MAX > 1) ? $clog2(c_PH_MAX) : 1;

    localparam logic [c_PH_W-1:0] c_PRE_LAST  = c_PH_W'(PRE_CYCLES - 1);
    localparam logic [c_PH_W-1:0] c_EVAL_LAST = c_PH_W'(EVAL_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_LAST_RND  = CNT_W'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRECH = 2'd1,
        S_EVAL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_round;
    logic [CNT_W-1:0]    w_round_nxt;
    logic [c_PH_W-1:0]   r_ph_cnt;
    logic [c_PH_W-1:0]   w_ph_nxt;
    logic                w_eval_end;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_round  <= '0;
            r_ph_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_round  <= w_round_nxt;
            r_ph_cnt <= w_ph_nxt;
        end
    end

    assign w_eval_end = (r_state == S_EVAL) && (r_ph_cnt == c_EVAL_LAST);

    // ------------------------------------------------------------------------
    // Next-state logic. EVAL always exits into PRECH or DONE, so no two
    // evaluate windows are ever adjacent without a precharge in between.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_ph_nxt    = r_ph_cnt;

        case (r_state)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    w_state_nxt = S_PRECH;
                    w_round_nxt = '0;
                    w_ph_nxt    = '0;
                end
            end
            S_PRECH: begin
                if (r_ph_cnt == c_PRE_LAST) begin
                    w_state_nxt = S_EVAL;
                    w_ph_nxt    = '0;
                end else begin
                    w_ph_nxt    = r_ph_cnt + 1'b1;
                end
            end
            S_EVAL: begin
                if (w_eval_end) begin
                    w_ph_nxt = '0;
                    if (r_round == c_LAST_RND) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_PRECH;
                        w_round_nxt = r_round + 1'b1;
                    end
                end else begin
                    w_ph_nxt = r_ph_cnt + 1'b1;
                end
            end
            S_DONE: begin
                // round stays at NUM_ROUNDS until the next start
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_round_nxt = '0;
                w_ph_nxt    = '0;
            end
        endcase

        // Abort overrides any phase/round advance.
        if (abort_i && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_round_nxt = '0;
            w_ph_nxt    = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all decoded from registered state so prech_o cannot glitch.
    // reg_en_o alone looks at abort_i so an aborted capture never lands.
    // ------------------------------------------------------------------------
    assign eval_o        = (r_state == S_EVAL);
    assign prech_o       = ~eval_o;
    assign busy_o        = (r_state == S_PRECH) || (r_state == S_EVAL);
    assign round_o       = r_round;
    assign first_round_o = busy_o && (r_round == '0);
    assign last_round_o  = busy_o && (r_round == c_LAST_RND);
    assign done_o        = (r_state == S_DONE);
    assign reg_en_o      = w_eval_end && !abort_i;

endmodule
`default_nettype wire

// File: tb/tb_wddl_round_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_wddl_round_seq
// Description : Self-checking bench for wddl_round_seq. Expected reg_en/done
//               events (cycle and round) are queued when a start is driven and
//               popped as the DUT produces them. A second instance runs with
//               PRE=2, EVAL=3, NUM_ROUNDS=14.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wddl_round_seq;

    typedef struct {
        int kind;   // 1 = reg_en pulse, 2 = done pulse
        int cyc;
        int rnd;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       start, abort, start2;
    logic       prech_o, eval_o, first_round_o, last_round_o, reg_en_o, busy_o, done_o;
    logic [3:0] round_o;
    logic       prech2, eval2, first2, last2, reg_en2, busy2, done2;
    logic [3:0] round2;

    int   cyc;
    int   n_total;
    int   n_bad;
    int   base;
    ev_t  q1[$];
    ev_t  q2[$];
    ev_t  m1e, m2e;

    wddl_round_seq dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .prech_o(prech_o), .eval_o(eval_o), .round_o(round_o),
        .first_round_o(first_round_o), .last_round_o(last_round_o),
        .reg_en_o(reg_en_o), .busy_o(busy_o), .done_o(done_o)
    );

    wddl_round_seq #(.NUM_ROUNDS(14), .PRE_CYCLES(2), .EVAL_CYCLES(3), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .abort_i(1'b0),
        .prech_o(prech2), .eval_o(eval2), .round_o(round2),
        .first_round_o(first2), .last_round_o(last2),
        .reg_en_o(reg_en2), .busy_o(busy2), .done_o(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Queue every event one operation should produce, relative to the cycle
    // in which start is presented.
    task automatic push_op(input int sel, input int b, input int pre, input int ev, input int nr);
        ev_t e;
        for (int r = 0; r <= nr; r++) begin
            e = '{1, b + (r + 1) * (pre + ev), r};
            if (sel == 1) q1.push_back(e); else q2.push_back(e);
        end
        e = '{2, b + 1 + (nr + 1) * (pre + ev), nr};
        if (sel == 1) q1.push_back(e); else q2.push_back(e);
    endtask

    task automatic drop_from(input int c);
        ev_t tmp[$];
        foreach (q1[i]) if (q1[i].cyc < c) tmp.push_back(q1[i]);
        q1 = tmp;
    endtask

    task automatic drain(input int sel, input int budget);
        for (int i = 0; i < budget; i++) begin
            if ((sel == 1 ? q1.size() : q2.size()) == 0) break;
            @(posedge clk);
        end
        #1;
        check(sel == 1 ? "drain1" : "drain2", sel == 1 ? q1.size() : q2.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_prech"},  int'(prech_o), 1);
        check({tag, "_eval"},   int'(eval_o), 0);
        check({tag, "_round"},  int'(round_o), 0);
        check({tag, "_busy"},   int'(busy_o), 0);
        check({tag, "_done"},   int'(done_o), 0);
        check({tag, "_reg_en"}, int'(reg_en_o), 0);
        check({tag, "_first"},  int'(first_round_o), 0);
        check({tag, "_last"},   int'(last_round_o), 0);
    endtask

    // Monitor for the default instance.
    always @(negedge clk) begin
        if (rst_n) begin
            check("phase_compl", int'(prech_o ^ eval_o), 1);
            if (reg_en_o || done_o) begin
                if (q1.size() == 0) begin
                    check("unexpected_event", int'(done_o) + 1, 0);
                end else begin
                    m1e = q1.pop_front();
                    check("ev_kind",  done_o ? 2 : 1, m1e.kind);
                    check("ev_cycle", cyc, m1e.cyc);
                    check("ev_round", int'(round_o), m1e.rnd);
                end
            end
        end
    end

    // Monitor for the PRE=2 / EVAL=3 / 14-round instance.
    always @(negedge clk) begin
        if (rst_n) begin
            check("phase_compl2", int'(prech2 ^ eval2), 1);
            if (reg_en2 || done2) begin
                if (q2.size() == 0) begin
                    check("unexpected_event2", int'(done2) + 1, 0);
                end else begin
                    m2e = q2.pop_front();
                    check("ev2_kind",  done2 ? 2 : 1, m2e.kind);
                    check("ev2_cycle", cyc, m2e.cyc);
                    check("ev2_round", int'(round2), m2e.rnd);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        start2  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset values
        @(negedge clk);
        check_reset_vals("rst");
        check("rst2_prech", int'(prech2), 1);

        // Default run with per-cycle flag checks
        @(posedge clk); #1;
        base  = cyc;
        start = 1'b1;
        push_op(1, base, 1, 2, 10);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            check("first_round", int'(first_round_o), int'(k <= 3));
            check("last_round",  int'(last_round_o), int'(k >= 31 && k <= 33));
            check("round",       int'(round_o), (k <= 33) ? (k - 1) / 3 : 10);
            check("busy",        int'(busy_o), int'(k <= 33));
        end
        drain(1, 10);

        // start held high: DONE ignores it, IDLE at +35 begins the next op
        @(posedge clk); #1;
        base  = cyc;
        start = 1'b1;
        push_op(1, base, 1, 2, 10);
        repeat (35) @(posedge clk);
        #1;
        push_op(1, base + 35, 1, 2, 10);
        repeat (5) @(posedge clk);
        #1 start = 1'b0;
        drain(1, 100);
        repeat (5) @(posedge clk);

        // Abort in the round-4 capture cycle
        @(posedge clk); #1;
        base  = cyc;
        start = 1'b1;
        push_op(1, base, 1, 2, 10);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        drop_from(base + 15);
        check("abort_round_pre", int'(round_o), 4);
        abort = 1'b1;
        #1;
        check("abort_reg_en", int'(reg_en_o), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check_reset_vals("abort");
        repeat (40) @(posedge clk);
        #1 check("abort_q_empty", q1.size(), 0);

        // Asynchronous reset mid-operation
        @(posedge clk); #1;
        base  = cyc;
        start = 1'b1;
        push_op(1, base, 1, 2, 10);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("areset_busy_pre", int'(busy_o), 1);
        drop_from(base + 20);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("areset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        base  = cyc;
        start = 1'b1;
        push_op(1, base, 1, 2, 10);
        @(posedge clk); #1;
        start = 1'b0;
        drain(1, 60);

        // Second instance: PRE=2, EVAL=3, NUM_ROUNDS=14
        @(posedge clk); #1;
        base   = cyc;
        start2 = 1'b1;
        push_op(2, base, 2, 3, 14);
        @(posedge clk); #1;
        start2 = 1'b0;
        drain(2, 100);
        repeat (3) @(posedge clk);
        #1 check("final_q1_empty", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
